// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a framed byte stream (length, words, XOR checksum),
// writes each assembled word to imem and releases the core reset only once the image is verified.
module imem_loader #(
    parameter int unsigned MAX_WORDS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [9:0]  imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [7:0]  len_hi;
    logic [7:0]  csum;
    logic [9:0]  word_idx;
    logic [9:0]  last_idx;
    logic [1:0]  byte_idx;
    logic [31:0] asm_word;

    logic [15:0] frame_len;
    logic        len_bad;
    logic [31:0] next_word;
    logic        accept;

    assign frame_len = {len_hi, in_data};
    assign len_bad   = (frame_len == '0) || (frame_len > 16'(MAX_WORDS));
    assign next_word = {asm_word[23:0], in_data};
    assign in_ready  = rst && (state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM});
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_LEN_HI;
            len_hi     <= '0;
            csum       <= '0;
            word_idx   <= '0;
            last_idx   <= '0;
            byte_idx   <= '0;
            asm_word   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                if (state != S_CSUM)
                    csum <= csum ^ in_data;
                case (state)
                    S_LEN_HI: begin
                        len_hi <= in_data;
                        state  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        if (len_bad) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else begin
                            // N <= MAX_WORDS <= 1024, so the low 10 bits minus one give the last index
                            last_idx <= frame_len[9:0] - 10'd1;
                            word_idx <= '0;
                            byte_idx <= '0;
                            state    <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        asm_word <= next_word;
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= word_idx;
                            imem_wdata <= next_word;
                            word_idx   <= word_idx + 10'd1;
                            byte_idx   <= '0;
                            if (word_idx == last_idx)
                                state <= S_CSUM;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                    S_CSUM: begin
                        if (in_data == csum) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a frame-position model predicts every output each cycle,
// and literal expectations pin the nominal, error and max-size results.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    imem_loader #(.MAX_WORDS(1000)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks the position inside the frame and derives outputs from the frame layout.
    int          m_pos = 0;
    int          m_n = 0;
    logic [7:0]  m_x = '0;
    logic [31:0] m_word = '0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic        m_we = 1'b0;
    logic [9:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_pos = 0; m_n = 0; m_x = '0; m_word = '0;
            m_done = 1'b0; m_err = 1'b0; m_we = 1'b0;
        end else begin
            m_we = 1'b0;
            if (in_valid && !m_done && !m_err) begin
                if (m_pos == 0) begin
                    m_n = int'(in_data) * 256;
                    m_x = m_x ^ in_data;
                end else if (m_pos == 1) begin
                    m_n = m_n + int'(in_data);
                    m_x = m_x ^ in_data;
                    if (m_n == 0 || m_n > 1000) m_err = 1'b1;
                end else if (m_pos < 2 + 4 * m_n) begin
                    m_x = m_x ^ in_data;
                    m_word = {m_word[23:0], in_data};
                    if ((m_pos - 2) % 4 == 3) begin
                        m_we = 1'b1;
                        m_addr = 10'((m_pos - 2) / 4);
                        m_data = m_word;
                    end
                end else begin
                    if (in_data == m_x) m_done = 1'b1;
                    else m_err = 1'b1;
                end
                m_pos++;
            end
        end
    end

    logic [9:0]  wr_a[$];
    logic [31:0] wr_d[$];

    always @(negedge clk) begin
        #1;
        check("in_ready", 32'(in_ready), 32'(rst && !m_done && !m_err));
        check("imem_we", 32'(imem_we), 32'(m_we));
        if (m_we) begin
            check("imem_waddr", 32'(imem_waddr), 32'(m_addr));
            check("imem_wdata", imem_wdata, m_data);
        end
        check("done", 32'(done), 32'(m_done));
        check("error", 32'(error), 32'(m_err));
        check("cpu_rst", 32'(cpu_rst), 32'(!m_done));
        if (imem_we === 1'b1) begin
            wr_a.push_back(imem_waddr);
            wr_d.push_back(imem_wdata);
        end
    end

    logic [7:0] frame[$];

    task automatic send_byte(input logic [7:0] b);
        int tries = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        check("accept_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_frame(input int gap, input int limit);
        for (int i = 0; i < frame.size() && i < limit; i++) begin
            send_byte(frame[i]);
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wr_a.delete();
        wr_d.delete();
    endtask

    task automatic load_nominal(input logic [7:0] last);
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, last};
    endtask

    task automatic check_nominal_writes(input string tag);
        check({tag, "_nwrites"}, 32'(wr_a.size()), 32'd2);
        if (wr_a.size() == 2) begin
            check({tag, "_addr0"}, 32'(wr_a[0]), 32'd0);
            check({tag, "_data0"}, wr_d[0], 32'h20080005);
            check({tag, "_addr1"}, 32'(wr_a[1]), 32'd1);
            check({tag, "_data1"}, wr_d[1], 32'h01095020);
        end
    endtask

    initial begin
        logic [7:0] x;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_waddr", 32'(imem_waddr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("first_ready", 32'(in_ready), 32'd1);

        // Nominal load
        load_nominal(8'h57);
        send_frame(0, 100);
        check_nominal_writes("nom");
        check("nom_done", 32'(done), 32'd1);
        check("nom_cpu_rst", 32'(cpu_rst), 32'd0);
        check("nom_error", 32'(error), 32'd0);
        check("nom_model_done", 32'(m_done), 32'd1);

        // Bad checksum
        do_reset();
        load_nominal(8'h56);
        send_frame(0, 100);
        check_nominal_writes("badcs");
        check("badcs_error", 32'(error), 32'd1);
        check("badcs_done", 32'(done), 32'd0);
        check("badcs_cpu_rst", 32'(cpu_rst), 32'd1);
        check("badcs_ready", 32'(in_ready), 32'd0);

        // Zero length
        do_reset();
        frame = '{8'h00, 8'h00};
        send_frame(0, 100);
        check("len0_error", 32'(error), 32'd1);
        check("len0_writes", 32'(wr_a.size()), 32'd0);

        // Length 1001
        do_reset();
        frame = '{8'h03, 8'hE9};
        send_frame(0, 100);
        check("len1001_error", 32'(error), 32'd1);
        check("len1001_writes", 32'(wr_a.size()), 32'd0);
        check("len1001_cpu_rst", 32'(cpu_rst), 32'd1);

        // Gaps of 3 cycles between every byte
        do_reset();
        load_nominal(8'h57);
        send_frame(3, 100);
        check_nominal_writes("gap");
        check("gap_done", 32'(done), 32'd1);

        // Reset after the 6th byte, then full frame
        do_reset();
        load_nominal(8'h57);
        send_frame(0, 6);
        do_reset();
        send_frame(0, 100);
        check_nominal_writes("midrst");
        check("midrst_done", 32'(done), 32'd1);

        // Maximum image: 1000 words, word k = k
        do_reset();
        frame.delete();
        frame.push_back(8'h03);
        frame.push_back(8'hE8);
        for (int k = 0; k < 1000; k++) begin
            frame.push_back(8'h00);
            frame.push_back(8'h00);
            frame.push_back(8'(k >> 8));
            frame.push_back(8'(k & 255));
        end
        x = '0;
        foreach (frame[i]) x = x ^ frame[i];
        frame.push_back(x);
        send_frame(0, 5000);
        check("max_nwrites", 32'(wr_a.size()), 32'd1000);
        if (wr_a.size() == 1000) begin
            check("max_last_addr", 32'(wr_a[999]), 32'd999);
            check("max_last_data", wr_d[999], 32'd999);
            check("max_mid_addr", 32'(wr_a[500]), 32'd500);
        end
        check("max_done", 32'(done), 32'd1);
        check("max_cpu_rst", 32'(cpu_rst), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
